// File: rtl/reg_file_sb.sv
// Integer register file for the rv32i core: two combinational read ports, one write port,
// and a per-register busy scoreboard for RAW hazard detection. Optional macro: RF_BYPASS_EN.
module reg_file_sb #(
    parameter int n = 32,
    parameter int a = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [a-1:0]      rs1_addr,
    input  logic [a-1:0]      rs2_addr,
    output logic [n-1:0]      rs1_data,
    output logic [n-1:0]      rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [a-1:0]      wr_addr,
    input  logic [n-1:0]      wr_data,
    input  logic              issue_en,
    input  logic [a-1:0]      issue_rd,
    output logic [(2**a)-1:0] busy_vec
);

    localparam int NREG = 2 ** a;
    localparam logic [a-1:0] ZERO_ADDR = {a{1'b0}};
    localparam logic [n-1:0] ZERO_DATA = {n{1'b0}};

    logic [n-1:0]    regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            wr_hit_s;
    logic            issue_hit_s;

    // Writes and issues aimed at x0 are dropped here, so nothing downstream needs to care.
    assign wr_hit_s    = wr_en && (wr_addr != ZERO_ADDR);
    assign issue_hit_s = issue_en && (issue_rd != ZERO_ADDR);

    // Next scoreboard state: a new producer outranks a retiring one on the same register.
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            if (issue_hit_s && (issue_rd == a'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_hit_s && (wr_addr == a'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Register storage and scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
            busy_r <= {NREG{1'b0}};
        end else begin
            if (wr_hit_s) begin
                regs_r[wr_addr] <= wr_data;
            end else begin
                regs_r[wr_addr] <= regs_r[wr_addr];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Read port 1 (x0 reads as zero and never busy).
    always_comb begin
        rs1_data = ZERO_DATA;
        rs1_busy = 1'b0;
        if (rs1_addr == ZERO_ADDR) begin
            rs1_data = ZERO_DATA;
            rs1_busy = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (wr_hit_s && (rs1_addr == wr_addr)) begin
            rs1_data = wr_data;
            rs1_busy = issue_hit_s && (issue_rd == wr_addr);
        end
`endif
        else begin
            rs1_data = regs_r[rs1_addr];
            rs1_busy = busy_r[rs1_addr];
        end
    end

    // Read port 2 (x0 reads as zero and never busy).
    always_comb begin
        rs2_data = ZERO_DATA;
        rs2_busy = 1'b0;
        if (rs2_addr == ZERO_ADDR) begin
            rs2_data = ZERO_DATA;
            rs2_busy = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (wr_hit_s && (rs2_addr == wr_addr)) begin
            rs2_data = wr_data;
            rs2_busy = issue_hit_s && (issue_rd == wr_addr);
        end
`endif
        else begin
            rs2_data = regs_r[rs2_addr];
            rs2_busy = busy_r[rs2_addr];
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a reference model feeds a queue of expected
// read results that are popped and compared against the DUT after each edge.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, wr_en, issue_en;
    logic [31:0] busy_vec;

    typedef struct {
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    int          n_checks = 0;
    int          n_fail   = 0;

    reg_file_sb #(.n(32), .a(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
    endtask

    // Apply the current inputs to the model, clock the DUT, then idle the controls.
    task automatic tick();
        if (wr_en && wr_addr != 5'd0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        issue_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = 5'd0; wr_data = 32'h0; issue_rd = 5'd0;
        rs1_addr = 5'd3; rs2_addr = 5'd31;
        model_reset();
        #12;
        n_checks++;
        if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy_vec got %h exp %h", busy_vec, 32'h0); end
        n_checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h/%h exp 0", rs1_data, rs2_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
    endtask

    task automatic test_write_read();
        rs1_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
`ifdef RF_BYPASS_EN
        exp_q.push_back('{data: 32'hDEADBEEF, busy: 1'b0});
`else
        exp_q.push_back('{data: 32'h0, busy: 1'b0});
`endif
        e = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== e.data) begin n_fail++; $display("FAIL wr_pre_edge got %h exp %h", rs1_data, e.data); end
        exp_q.push_back('{data: 32'hDEADBEEF, busy: 1'b0});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== e.data) begin n_fail++; $display("FAIL wr_post_edge got %h exp %h", rs1_data, e.data); end
    endtask

    task automatic test_x0();
        rs2_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        #1;
        n_checks++;
        if (rs2_data !== 32'h0 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL x0_pre got %h/%b exp 0/0", rs2_data, rs2_busy);
        end
        tick();
        n_checks++;
        if (rs2_data !== 32'h0 || rs2_busy !== 1'b0 || busy_vec[0] !== 1'b0) begin
            n_fail++; $display("FAIL x0_post got %h/%b/%b exp 0/0/0", rs2_data, rs2_busy, busy_vec[0]);
        end
    endtask

    task automatic test_issue_retire();
        rs1_addr = 5'd7;
        issue_en = 1'b1; issue_rd = 5'd7;
        tick();
        n_checks++;
        if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL issue_busy got %b exp 1", rs1_busy); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        #1;
`ifdef RF_BYPASS_EN
        exp_q.push_back('{data: 32'h12345678, busy: 1'b0});
`else
        exp_q.push_back('{data: 32'h0, busy: 1'b1});
`endif
        e = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== e.data || rs1_busy !== e.busy) begin
            n_fail++; $display("FAIL retire_pre got %h/%b exp %h/%b", rs1_data, rs1_busy, e.data, e.busy);
        end
        tick();
        n_checks++;
        if (rs1_data !== 32'h12345678 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL retire_post got %h/%b exp 12345678/0", rs1_data, rs1_busy);
        end
    endtask

    task automatic test_same_edge();
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        issue_en = 1'b1; issue_rd = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        n_checks++;
        if (rs2_data !== 32'hA5A5A5A5 || rs2_busy !== 1'b1) begin
            n_fail++; $display("FAIL same_pre got %h/%b exp a5a5a5a5/1", rs2_data, rs2_busy);
        end
`else
        n_checks++;
        if (rs2_data !== 32'h0 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL same_pre got %h/%b exp 0/0", rs2_data, rs2_busy);
        end
`endif
        tick();
        n_checks++;
        if (rs1_data !== 32'hA5A5A5A5 || busy_vec[9] !== 1'b1 || rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL same_post got %h/%b/%b exp a5a5a5a5/1/1", rs1_data, busy_vec[9], rs1_busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k < 31; k++) begin
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = $urandom;
            issue_en = (k % 3) == 0; issue_rd = 5'(k + 1);
            tick();
        end
        for (int r = 0; r < 32; r++) exp_q.push_back('{data: m_regs[r], busy: m_busy[r]});
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r); rs2_addr = 5'(31 - r);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rs1_data !== e.data || rs1_busy !== e.busy) begin
                n_fail++; $display("FAIL b2b_reg%0d got %h/%b exp %h/%b", r, rs1_data, rs1_busy, e.data, e.busy);
            end
            n_checks++;
            if (rs2_data !== m_regs[31 - r] || rs2_busy !== m_busy[31 - r]) begin
                n_fail++; $display("FAIL b2b_rs2_reg%0d got %h/%b exp %h/%b", 31 - r, rs2_data, rs2_busy, m_regs[31 - r], m_busy[31 - r]);
            end
        end
        n_checks++;
        if (busy_vec !== m_busy) begin n_fail++; $display("FAIL b2b_busy_vec got %h exp %h", busy_vec, m_busy); end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b0; wr_addr = 5'($urandom_range(0, 31)); wr_data = $urandom;
            issue_en = 1'b0; issue_rd = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        for (int r = 1; r < 32; r++) exp_q.push_back('{data: m_regs[r], busy: m_busy[r]});
        for (int r = 1; r < 32; r++) begin
            rs1_addr = 5'(r);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rs1_data !== e.data || rs1_busy !== e.busy) begin
                n_fail++; $display("FAIL hold_reg%0d got %h/%b exp %h/%b", r, rs1_data, rs1_busy, e.data, e.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        rs1_addr = 5'd12; rs2_addr = 5'd4;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFEF00D;
        issue_en = 1'b1; issue_rd = 5'd4;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy_vec !== 32'h0 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset got %h/%h/%h exp 0/0/0", busy_vec, rs1_data, rs2_data);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; issue_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0 || rs2_busy !== 1'b0 || busy_vec !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_release got %h/%b/%h exp 0/0/0", rs1_data, rs2_busy, busy_vec);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_issue_retire();
        test_same_edge();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
